// File: rtl/mem_arb_pkg.sv
// Shared encodings for the I-cache/D-cache memory arbiter: requester IDs,
// arbiter states and the default outstanding-read depth.
package mem_arb_pkg;

   localparam logic ID_IC = 1'b0;
   localparam logic ID_DC = 1'b1;

   localparam int MAX_OUT_DEF = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_OWN_IC = 2'd1,
      ST_OWN_DC = 2'd2
   } arb_state_t;

   function automatic arb_state_t own_state(input logic id);
      return (id == ID_DC) ? ST_OWN_DC : ST_OWN_IC;
   endfunction

endpackage

// File: rtl/mem_arb_id_fifo.sv
// In-order FIFO of 1-bit requester IDs, one entry per outstanding memory read.
// Push while full and pop while empty are ignored.
module mem_arb_id_fifo #(
   parameter int DEPTH = 4
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_push,
   input  logic i_din,
   input  logic i_pop,
   output logic o_full,
   output logic o_empty,
   output logic o_head
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [DEPTH-1:0] r_mem;
   logic [PW-1:0]    r_wptr;
   logic [PW-1:0]    r_rptr;
   logic [CW-1:0]    r_cnt;
   logic             w_push;
   logic             w_pop;

   // Wrap explicitly so a depth of one keeps both pointers at zero.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;
   assign o_full  = (r_cnt == CW'(DEPTH));
   assign o_empty = (r_cnt == '0);
   assign o_head  = r_mem[r_rptr];

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_mem  <= '0;
         r_wptr <= '0;
         r_rptr <= '0;
         r_cnt  <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wptr] <= i_din;
            r_wptr        <= ptr_inc(r_wptr);
         end
         if (w_pop)
            r_rptr <= ptr_inc(r_rptr);
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one word-granular memory port between the I-cache and D-cache.
// Tie-break: MEM_ARB_RR_EN selects round-robin, otherwise the D-cache wins ties.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int MAX_OUT = MAX_OUT_DEF,
   parameter int AW      = 32,
   parameter int DW      = 32
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_ic_ren,
   input  logic [AW-1:0] i_ic_addr,
   output logic          o_ic_ready,
   output logic [DW-1:0] o_ic_rdata,
   output logic          o_ic_valid,
   input  logic          i_dc_ren,
   input  logic          i_dc_wen,
   input  logic [AW-1:0] i_dc_addr,
   input  logic [DW-1:0] i_dc_wdata,
   output logic          o_dc_ready,
   output logic [DW-1:0] o_dc_rdata,
   output logic          o_dc_valid,
   input  logic          i_mem_ready,
   output logic [AW-1:0] o_mem_addr,
   output logic          o_mem_ren,
   output logic          o_mem_wen,
   output logic [DW-1:0] o_mem_wdata,
   input  logic [DW-1:0] i_mem_rdata,
   input  logic          i_mem_valid
);

   arb_state_t r_state;
`ifdef MEM_ARB_RR_EN
   logic       r_rr_pri;
`endif

   logic w_dc_req;
   logic w_any_req;
   logic w_tie_gnt;
   logic w_idle_gnt;
   logic w_own_vld;
   logic w_own;
   logic w_own_ren;
   logic w_own_wen;
   logic w_rdy;
   logic w_push;
   logic w_pop;
   logic w_fifo_full;
   logic w_fifo_empty;
   logic w_fifo_head;

   assign w_dc_req  = i_dc_ren | i_dc_wen;
   assign w_any_req = i_ic_ren | w_dc_req;

`ifdef MEM_ARB_RR_EN
   assign w_tie_gnt = r_rr_pri;
`else
   assign w_tie_gnt = ID_DC;
`endif

   assign w_idle_gnt = (i_ic_ren && w_dc_req) ? w_tie_gnt :
                       (w_dc_req ? ID_DC : ID_IC);

   // Owner is the IDLE-cycle winner (no bubble) or the registered grant.
   always_comb begin
      w_own_vld = 1'b0;
      w_own     = ID_IC;
      case (r_state)
         ST_IDLE: begin
            w_own_vld = w_any_req;
            w_own     = w_idle_gnt;
         end
         ST_OWN_IC: begin
            w_own_vld = 1'b1;
            w_own     = ID_IC;
         end
         ST_OWN_DC: begin
            w_own_vld = 1'b1;
            w_own     = ID_DC;
         end
         default: ;
      endcase
   end

   assign w_own_ren = w_own_vld && ((w_own == ID_IC) ? i_ic_ren : i_dc_ren);
   assign w_own_wen = w_own_vld && (w_own == ID_DC) && i_dc_wen;
   assign w_rdy     = i_mem_ready && !(w_own_ren && w_fifo_full);

   assign o_mem_ren   = w_own_ren && !w_fifo_full;
   assign o_mem_wen   = w_own_wen;
   assign o_mem_addr  = !w_own_vld ? '0 : ((w_own == ID_DC) ? i_dc_addr : i_ic_addr);
   assign o_mem_wdata = (w_own_vld && (w_own == ID_DC)) ? i_dc_wdata : '0;

   assign o_ic_ready = w_own_vld && (w_own == ID_IC) && w_rdy;
   assign o_dc_ready = w_own_vld && (w_own == ID_DC) && w_rdy;

   assign w_push = o_mem_ren && i_mem_ready;
   assign w_pop  = i_mem_valid && !w_fifo_empty;

   // Responses with nothing outstanding (e.g. pre-reset reads) are dropped.
   assign o_ic_valid = w_pop && (w_fifo_head == ID_IC);
   assign o_dc_valid = w_pop && (w_fifo_head == ID_DC);
   assign o_ic_rdata = i_mem_rdata;
   assign o_dc_rdata = i_mem_rdata;

   mem_arb_id_fifo #(
      .DEPTH (MAX_OUT)
   ) u_id_fifo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_push  (w_push),
      .i_din   (w_own),
      .i_pop   (w_pop),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty),
      .o_head  (w_fifo_head)
   );

   // While owning, every FIFO entry belongs to the owner, so an empty FIFO
   // means the owner has no reads left in flight.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state  <= ST_IDLE;
`ifdef MEM_ARB_RR_EN
         r_rr_pri <= ID_IC;
`endif
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_any_req) begin
                  r_state  <= own_state(w_idle_gnt);
`ifdef MEM_ARB_RR_EN
                  r_rr_pri <= ~w_idle_gnt;
`endif
               end
            end
            ST_OWN_IC: if (!i_ic_ren && w_fifo_empty) r_state <= ST_IDLE;
            ST_OWN_DC: if (!w_dc_req && w_fifo_empty) r_state <= ST_IDLE;
            default:   r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter; expectations adapt to MEM_ARB_RR_EN.
`timescale 1ns/1ps
module tb_mem_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
`ifdef MEM_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic          i_clk = 1'b0;
   logic          i_rst;
   logic          i_ic_ren;
   logic [AW-1:0] i_ic_addr;
   logic          o_ic_ready;
   logic [DW-1:0] o_ic_rdata;
   logic          o_ic_valid;
   logic          i_dc_ren;
   logic          i_dc_wen;
   logic [AW-1:0] i_dc_addr;
   logic [DW-1:0] i_dc_wdata;
   logic          o_dc_ready;
   logic [DW-1:0] o_dc_rdata;
   logic          o_dc_valid;
   logic          i_mem_ready;
   logic [AW-1:0] o_mem_addr;
   logic          o_mem_ren;
   logic          o_mem_wen;
   logic [DW-1:0] o_mem_wdata;
   logic [DW-1:0] i_mem_rdata;
   logic          i_mem_valid;

   int n_vec = 0;
   int n_err = 0;

   mem_arbiter #(.MAX_OUT(4), .AW(AW), .DW(DW)) dut (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_ic_ren    (i_ic_ren),
      .i_ic_addr   (i_ic_addr),
      .o_ic_ready  (o_ic_ready),
      .o_ic_rdata  (o_ic_rdata),
      .o_ic_valid  (o_ic_valid),
      .i_dc_ren    (i_dc_ren),
      .i_dc_wen    (i_dc_wen),
      .i_dc_addr   (i_dc_addr),
      .i_dc_wdata  (i_dc_wdata),
      .o_dc_ready  (o_dc_ready),
      .o_dc_rdata  (o_dc_rdata),
      .o_dc_valid  (o_dc_valid),
      .i_mem_ready (i_mem_ready),
      .o_mem_addr  (o_mem_addr),
      .o_mem_ren   (o_mem_ren),
      .o_mem_wen   (o_mem_wen),
      .o_mem_wdata (o_mem_wdata),
      .i_mem_rdata (i_mem_rdata),
      .i_mem_valid (i_mem_valid)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic clr();
      i_ic_ren    = 1'b0;
      i_ic_addr   = '0;
      i_dc_ren    = 1'b0;
      i_dc_wen    = 1'b0;
      i_dc_addr   = '0;
      i_dc_wdata  = '0;
      i_mem_ready = 1'b1;
      i_mem_rdata = '0;
      i_mem_valid = 1'b0;
   endtask

   // Advance one cycle; inputs change 1ns after the edge, checks follow 2ns later.
   task automatic nxt();
      @(posedge i_clk);
      #1;
      clr();
   endtask

   task automatic ic_rd(input logic [AW-1:0] a);
      i_ic_ren  = 1'b1;
      i_ic_addr = a;
   endtask

   task automatic dc_rd(input logic [AW-1:0] a);
      i_dc_ren  = 1'b1;
      i_dc_addr = a;
   endtask

   task automatic resp(input logic [DW-1:0] d);
      i_mem_valid = 1'b1;
      i_mem_rdata = d;
   endtask

   // Tie loser of the first tie keeps requesting.
   task automatic hold_loser();
      if (RR) dc_rd(32'h500);
      else    ic_rd(32'h300);
   endtask

   initial begin
      // reset state
      i_rst = 1'b1;
      clr();
      #12;
      chk("rst_mem_ren", o_mem_ren, 0);
      chk("rst_mem_wen", o_mem_wen, 0);
      chk("rst_mem_addr", o_mem_addr, 0);
      resp(32'h1111);
      #1;
      chk("rst_valids", {o_ic_valid, o_dc_valid}, 2'b00);
      clr();
      @(negedge i_clk);
      i_rst = 1'b0;

      // first tie after reset: RR -> IC, fixed -> DC
      nxt(); ic_rd(32'h300); dc_rd(32'h500); #2;
      chk("tie1_rdy", {o_ic_ready, o_dc_ready}, RR ? 2'b10 : 2'b01);
      chk("tie1_addr", o_mem_addr, RR ? 32'h300 : 32'h500);
      chk("tie1_ren", o_mem_ren, 1);
      nxt(); hold_loser(); #2;
      chk("tie1_hold_rdy", {o_ic_ready, o_dc_ready}, RR ? 2'b10 : 2'b01);
      chk("tie1_hold_ren", o_mem_ren, 0);
      nxt(); hold_loser(); resp(32'hA0); #2;
      chk("tie1_rsp_vld", {o_ic_valid, o_dc_valid}, RR ? 2'b10 : 2'b01);
      chk("tie1_rsp_data", RR ? o_ic_rdata : o_dc_rdata, 32'hA0);
      nxt(); hold_loser(); #2;
      chk("tie1_drain_rdy", {o_ic_ready, o_dc_ready}, RR ? 2'b10 : 2'b01);
      // second tie: RR pointer now favours DC; fixed mode favours DC
      nxt(); ic_rd(32'h300); dc_rd(32'h500); #2;
      chk("tie2_rdy", {o_ic_ready, o_dc_ready}, 2'b01);
      chk("tie2_addr", o_mem_addr, 32'h500);
      nxt(); ic_rd(32'h300); #2;
      chk("tie2_hold_rdy", {o_ic_ready, o_dc_ready}, 2'b01);
      chk("tie2_hold_ren", o_mem_ren, 0);
      nxt(); ic_rd(32'h300); resp(32'hA1); #2;
      chk("tie2_rsp_vld", {o_ic_valid, o_dc_valid}, 2'b01);
      chk("tie2_rsp_data", o_dc_rdata, 32'hA1);
      nxt(); ic_rd(32'h300); #2;
      chk("tie2_drain_rdy", {o_ic_ready, o_dc_ready}, 2'b01);
      nxt(); ic_rd(32'h300); #2;
      chk("ic_late_rdy", {o_ic_ready, o_dc_ready}, 2'b10);
      chk("ic_late_addr", o_mem_addr, 32'h300);
      nxt(); resp(32'hA2); #2;
      chk("ic_late_vld", {o_ic_valid, o_dc_valid}, 2'b10);
      nxt();

      // I-cache line fill, responses two cycles behind requests
      for (int k = 0; k < 6; k++) begin
         nxt();
         if (k < 4) ic_rd(32'h100 + 32'(4 * k));
         if (k >= 2) resp(32'hF00 + 32'(k - 2));
         #2;
         if (k < 4) begin
            chk("fill_rdy", o_ic_ready, 1);
            chk("fill_addr", o_mem_addr, 32'h100 + 32'(4 * k));
         end
         chk("fill_vld", {o_ic_valid, o_dc_valid}, (k >= 2) ? 2'b10 : 2'b00);
         if (k >= 2) chk("fill_data", o_ic_rdata, 32'hF00 + 32'(k - 2));
      end
      nxt();

      // D-cache write while I-cache waits; writes owe no response
      nxt(); ic_rd(32'h600); i_dc_wen = 1'b1; i_dc_addr = 32'h40; i_dc_wdata = 32'hDEADBEEF; #2;
      chk("wr_wen", o_mem_wen, 1);
      chk("wr_ren", o_mem_ren, 0);
      chk("wr_addr", o_mem_addr, 32'h40);
      chk("wr_wdata", o_mem_wdata, 32'hDEADBEEF);
      chk("wr_rdy", {o_ic_ready, o_dc_ready}, 2'b01);
      nxt(); ic_rd(32'h600); #2;
      chk("wr_after_wen", o_mem_wen, 0);
      chk("wr_after_ren", o_mem_ren, 0);
      nxt(); ic_rd(32'h600); #2;
      chk("wr_ic_rdy", {o_ic_ready, o_dc_ready}, 2'b10);
      chk("wr_ic_addr", o_mem_addr, 32'h600);
      chk("wr_ic_wdata", o_mem_wdata, 0);
      nxt(); resp(32'hB0); #2;
      chk("wr_ic_vld", {o_ic_valid, o_dc_valid}, 2'b10);
      nxt();

      // FIFO full: four reads outstanding, fifth stalls, writes still pass
      for (int k = 0; k < 4; k++) begin
         nxt(); dc_rd(32'h800 + 32'(4 * k)); #2;
         chk("full_fill_rdy", o_dc_ready, 1);
      end
      nxt(); dc_rd(32'h810); #2;
      chk("full_stall_rdy", o_dc_ready, 0);
      chk("full_stall_ren", o_mem_ren, 0);
      nxt(); i_dc_wen = 1'b1; i_dc_addr = 32'h44; i_dc_wdata = 32'h1234; #2;
      chk("full_wr_rdy", o_dc_ready, 1);
      chk("full_wr_wen", o_mem_wen, 1);
      nxt(); dc_rd(32'h810); resp(32'hC0); #2;
      chk("full_pop_rdy", o_dc_ready, 0);
      chk("full_pop_vld", o_dc_valid, 1);
      chk("full_pop_data", o_dc_rdata, 32'hC0);
      nxt(); dc_rd(32'h810); #2;
      chk("refill_rdy", o_dc_ready, 1);
      nxt(); dc_rd(32'h814); resp(32'hC1); #2;
      chk("refull_rdy", o_dc_ready, 0);
      chk("refull_vld", o_dc_valid, 1);
      nxt(); dc_rd(32'h814); resp(32'hC2); #2;
      chk("pushpop_rdy", o_dc_ready, 1);
      chk("pushpop_vld", o_dc_valid, 1);
      nxt(); dc_rd(32'h818); #2;
      chk("pushpop_cnt_rdy", o_dc_ready, 1);
      nxt(); dc_rd(32'h81C); #2;
      chk("pushpop_full_rdy", o_dc_ready, 0);
      for (int k = 0; k < 4; k++) begin
         nxt(); resp(32'hC3 + 32'(k)); #2;
         chk("drain_vld", {o_ic_valid, o_dc_valid}, 2'b01);
         chk("drain_data", o_dc_rdata, 32'hC3 + 32'(k));
      end
      nxt(); resp(32'hDD); #2;
      chk("empty_drop", {o_ic_valid, o_dc_valid}, 2'b00);
      nxt();

      // reset between second request and first response
      nxt(); ic_rd(32'h900); #2;
      chk("prerst_rdy0", o_ic_ready, 1);
      nxt(); ic_rd(32'h904); #2;
      chk("prerst_rdy1", o_ic_ready, 1);
      nxt(); i_rst = 1'b1; #2;
      chk("midrst_ren", o_mem_ren, 0);
      i_rst = 1'b0;
      nxt(); resp(32'hE0); #2;
      chk("postrst_drop0", {o_ic_valid, o_dc_valid}, 2'b00);
      nxt(); resp(32'hE1); #2;
      chk("postrst_drop1", {o_ic_valid, o_dc_valid}, 2'b00);
      nxt(); dc_rd(32'hA00); #2;
      chk("postrst_idle_rdy", {o_ic_ready, o_dc_ready}, 2'b01);
      nxt(); resp(32'hE2); #2;
      chk("postrst_vld", {o_ic_valid, o_dc_valid}, 2'b01);
      chk("postrst_data", o_dc_rdata, 32'hE2);
      nxt();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
